// File: rtl/warp_scheduler_rr_pkg.sv
// Shared definitions for the round-robin warp scheduler and its arbiter.
package warp_scheduler_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    // Value every warp PC takes on reset.
    localparam int PC_RESET = 0;

    // Width of a warp id. Never below 1, so a 2-warp build still has a usable id port.
    function automatic int wid_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/warp_scheduler_rr_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr, wrapping modulo NUM_WARPS.
// Kept generic so the LSU arbiter can reuse it.
module rr_arbiter
    import warp_scheduler_rr_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int WID_W     = wid_width(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] request,
    input  logic [WID_W-1:0]     ptr,
    output logic [WID_W-1:0]     grant_id,
    output logic                 grant_valid
);

    logic [WID_W-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest requester is the last one written.
    // NUM_WARPS is a power of two, so the wrap is just the natural overflow of idx.
    always_comb begin
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = NUM_WARPS - 1; k >= 0; k--) begin
            idx = ptr + WID_W'(k);
            if (request[idx]) begin
                grant_id    = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler_rr.sv
// Round-robin warp scheduler. It keeps the PC, active and in-flight state of every warp
// and offers one eligible warp at a time to instruction fetch.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | after reset, no kernel loaded
// ST_RUN  | kernel running; warps are picked and issued to fetch
// ST_DONE | every warp has exited; all_done is high until the next start
module warp_scheduler_rr
    import warp_scheduler_rr_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int PC_WIDTH  = 8,
    parameter int WID_W     = wid_width(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_pc,
    input  logic [NUM_WARPS-1:0] warp_enable,
    input  logic [NUM_WARPS-1:0] ready_warps,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [WID_W-1:0]     warp_num,
    output logic [PC_WIDTH-1:0]  pc,
    input  logic                 pc_upd_valid,
    input  logic [WID_W-1:0]     pc_upd_warp,
    input  logic [PC_WIDTH-1:0]  pc_upd_pc,
    input  logic                 done_valid,
    input  logic [WID_W-1:0]     done_warp,
    output logic                 busy,
    output logic                 all_done
);

    sched_state_t         state, state_nx;
    logic [PC_WIDTH-1:0]  pc_r [NUM_WARPS];
    logic [NUM_WARPS-1:0] active;
    logic [NUM_WARPS-1:0] inflight;
    logic [WID_W-1:0]     rr_ptr;
    logic [NUM_WARPS-1:0] eligible;
    logic [WID_W-1:0]     grant_id;
    logic                 grant_valid;
    logic                 launch;
    logic                 handshake;

    // A start is taken from IDLE or DONE. A start that arrives during RUN is dropped.
    assign launch    = start && (state != ST_RUN);
    assign handshake = issue_valid && issue_ready;
    assign eligible  = active & ~inflight & ready_warps;

    rr_arbiter #(
        .NUM_WARPS (NUM_WARPS),
        .WID_W     (WID_W)
    ) u_arb (
        .request     (eligible),
        .ptr         (rr_ptr),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and the status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        all_done = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                all_done = (state == ST_DONE);
                if (start) state_nx = (warp_enable == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if ((active == '0) && !issue_valid) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Per-warp context. Statements are ordered so that the later write wins: a done event
    // overrides a PC writeback or a handshake aimed at the same warp.
    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= '0;
            inflight <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NUM_WARPS; i++) pc_r[i] <= PC_WIDTH'(PC_RESET);
        end else if (launch) begin
            active   <= warp_enable;
            inflight <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NUM_WARPS; i++) pc_r[i] <= start_pc;
        end else if (state == ST_RUN) begin
            if (handshake) begin
                inflight[warp_num] <= 1'b1;
                rr_ptr             <= warp_num + 1'b1;
            end
            if (pc_upd_valid && inflight[pc_upd_warp] && active[pc_upd_warp]) begin
                pc_r[pc_upd_warp]     <= pc_upd_pc;
                inflight[pc_upd_warp] <= 1'b0;
            end
            if (done_valid) begin
                active[done_warp]   <= 1'b0;
                inflight[done_warp] <= 1'b0;
            end
        end
    end

    // Issue register: the offer is held stable until fetch takes it. A new warp is picked
    // only while no offer is outstanding, which also rules out a pick in the handshake cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid <= 1'b0;
            warp_num    <= '0;
            pc          <= '0;
        end else if (state == ST_RUN) begin
            if (issue_valid) begin
                if (issue_ready) issue_valid <= 1'b0;
            end else if (grant_valid) begin
                issue_valid <= 1'b1;
                warp_num    <= grant_id;
                pc          <= pc_r[grant_id];
            end
        end else begin
            issue_valid <= 1'b0;
        end
    end

endmodule

// File: doc/warp_scheduler_rr.md
Name: warp_scheduler_rr

Overview:
- Parametrised successor to the fixed 4-warp scheduler.
- Holds per-warp PC, active and in-flight state for NUM_WARPS warps, and picks one ready warp per issue using a round-robin pointer.
- Presents the chosen warp's id and PC to instruction fetch over a valid/ready handshake.
- Sits between the readiness check/scoreboard (supplies ready_warps) and instruction fetch/decode (returns PC updates and warp-done events).

Parameters:
- NUM_WARPS, 4, number of warp contexts; power of two, 2..16.
- PC_WIDTH, 8, width of each warp PC.
- WID_W, $clog2(NUM_WARPS), derived width of a warp id; not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; launches a kernel
- start_pc  in  PC_WIDTH  initial PC loaded into every enabled warp
- warp_enable  in  NUM_WARPS  warps taking part in the kernel; sampled on start
- ready_warps  in  NUM_WARPS  per-warp scoreboard readiness
- issue_valid  out  1  issue request valid
- issue_ready  in  1  fetch accepts the issue
- warp_num  out  WID_W  warp being issued
- pc  out  PC_WIDTH  PC of the issued warp
- pc_upd_valid  in  1  next-PC writeback
- pc_upd_warp  in  WID_W  warp for the PC writeback
- pc_upd_pc  in  PC_WIDTH  new PC value
- done_valid  in  1  warp hit its exit instruction
- done_warp  in  WID_W  warp that finished
- busy  out  1  scheduler is in RUN
- all_done  out  1  kernel complete

Behaviour:
- Reset values: all outputs 0; state IDLE; every pc_r, active and inflight cleared; rr_ptr 0.
- Reset asserted mid-operation aborts the kernel immediately with the same values.
- IDLE -> RUN on start:
  - active <= warp_enable, pc_r[i] <= start_pc, inflight <= 0, rr_ptr <= 0.
  - If warp_enable == 0, go straight to DONE.
- RUN:
  - eligible = active & ~inflight & ready_warps.
  - When issue_valid == 0 and eligible != 0, choose the first eligible warp at or after rr_ptr (modulo NUM_WARPS).
  - Next cycle: issue_valid = 1, warp_num = that id, pc = its pc_r. Latency is 1 cycle from eligibility to issue_valid.
  - issue_valid, warp_num and pc stay stable until issue_valid & issue_ready. They are not retracted if ready_warps drops meanwhile.
  - On handshake: inflight[w] <= 1, rr_ptr <= w+1 (wraps), issue_valid <= 0.
  - No selection happens in the handshake cycle, so peak issue rate is 1 per 2 cycles.
- pc_upd_valid for warp w with inflight[w]: pc_r[w] <= pc_upd_pc, inflight[w] <= 0.
  - The update is ignored if w is not in flight or not active.
- done_valid for warp w: active[w] <= 0, inflight[w] <= 0.
  - done_valid and pc_upd_valid for the same warp in the same cycle: done wins, PC is unchanged.
  - Updates or done for different warps in the same cycle as a handshake all take effect.
- RUN -> DONE when active becomes 0 and issue_valid is 0.
- DONE: all_done = 1, busy = 0; holds until the next start, then goes to RUN as from IDLE.
- start while in RUN is ignored.
- busy = 1 exactly in RUN.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE), WID_W derivation function, PC reset constant.
- One sub-module, rr_arbiter: combinational, with request[NUM_WARPS] and ptr in, grant_id and grant_valid out. It is reused later by the LSU arbiter.
- Per-warp registers stay in the top module as arrays.

Test Plan:
- Reset mid-RUN (warps 0-3 active, issue_valid high) -> next cycle issue_valid=0, busy=0, all_done=0, all PCs 0.
- start, start_pc=0x10, warp_enable=4'b1111, ready_warps=1111, issue_ready=1, each issued warp updated 2 cycles later to pc+1 -> issue order 0,1,2,3,0 with pc 0x10 for each first issue, then 0x11 for warp 0.
- ready_warps=4'b0100 only -> only warp 2 issues; raise bit 0 while warp 2 is in flight -> next issue is warp 0.
- issue_ready held low 5 cycles while ready_warps drops to 0 -> warp_num and pc stay stable and valid stays 1; handshake on cycle 6.
- Same-cycle done_valid and pc_upd_valid for warp 1 (pc 0x22) -> warp 1 is never issued again and its pc is not updated.
- warp_enable=4'b0011, done for warp 0 then warp 1 -> RUN to DONE, all_done=1, busy=0.
- warp_enable=0 -> DONE the cycle after start.
- NUM_WARPS=8 build -> round-robin wraps from 7 to 0.
